// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO drain scheduler.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int ARB_BUF_DEPTH = 2;

    // Next source index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: picks the first requester at or after ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] idx_s;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        gnt_idx = {IW{1'b0}};
        gnt_vld = 1'b0;
        idx_s   = {IW{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            idx_s = IW'((int'(ptr) + k) % N);
            if (req[idx_s]) begin
                gnt_idx = idx_s;
                gnt_vld = 1'b1;
            end else begin
                gnt_vld = gnt_vld;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin burst reader sharing one valid/ready consumer among NUM_SRC fifo4 sources.
// Words are tagged with their source index and pass through a 2-entry output buffer.
module fifo_rr_drain
    import fifo_arb_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_SRC = 4,
    parameter  int BURST   = 4,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_SRC-1:0]         src_empty,
    input  logic [NUM_SRC-1:0]         src_one_left,
    input  logic [NUM_SRC*WIDTH-1:0]   src_rd_data,
    output logic [NUM_SRC-1:0]         src_rd_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [SRC_W-1:0]           out_src,
    output logic                       busy
);

    localparam int              CNT_W   = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    arb_state_e        state_r, state_s;
    logic [SRC_W-1:0]  grant_r, grant_s;
    logic [SRC_W-1:0]  rr_ptr_r, rr_ptr_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              armed_r;
    logic              inflight_r;
    logic [SRC_W-1:0]  infl_src_r;

    logic [WIDTH-1:0]  buf_data_r [ARB_BUF_DEPTH];
    logic [SRC_W-1:0]  buf_src_r  [ARB_BUF_DEPTH];
    logic              buf_wp_r, buf_rp_r;
    logic [1:0]        buf_cnt_r;

    logic [SRC_W-1:0]  pick_idx_s;
    logic              pick_vld_s;
    logic              issue_s;
    logic [SRC_W-1:0]  issue_idx_s;
    logic              pop_s, push_s, bpop_s, credit_s;
    logic [2:0]        occ_s;
    logic [WIDTH-1:0]  infl_data_s;

    rr_pick #(.N(NUM_SRC), .IW(SRC_W)) u_pick (
        .req     (~src_empty),
        .ptr     (rr_ptr_r),
        .gnt_idx (pick_idx_s),
        .gnt_vld (pick_vld_s)
    );

    // The in-flight word counts against the buffer so a read never lacks a landing slot.
    assign pop_s       = out_valid & out_ready;
    assign occ_s       = {1'b0, buf_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign credit_s    = (occ_s < 3'd2);
    assign infl_data_s = src_rd_data[int'(infl_src_r) * WIDTH +: WIDTH];
    assign push_s      = inflight_r & ~((buf_cnt_r == 2'd0) & pop_s);
    assign bpop_s      = pop_s & (buf_cnt_r != 2'd0);
    assign busy        = (state_r == ARB_BURST) | inflight_r | (buf_cnt_r != 2'd0);

    // Grant / burst FSM next-state and read-issue decision.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        rr_ptr_s    = rr_ptr_r;
        cnt_s       = cnt_r;
        issue_s     = 1'b0;
        issue_idx_s = grant_r;
        case (state_r)
            ARB_IDLE: begin
                if (armed_r && en && pick_vld_s) begin
                    grant_s     = pick_idx_s;
                    issue_idx_s = pick_idx_s;
                    state_s     = ARB_BURST;
                    if (credit_s) begin
                        issue_s = 1'b1;
                        cnt_s   = CNT_W'(1);
                        if ((BURST_C == CNT_W'(1)) || src_one_left[pick_idx_s]) begin
                            state_s  = ARB_IDLE;
                            cnt_s    = {CNT_W{1'b0}};
                            rr_ptr_s = SRC_W'(wrap_inc(int'(pick_idx_s), NUM_SRC));
                        end else begin
                            state_s = ARB_BURST;
                        end
                    end else begin
                        cnt_s = {CNT_W{1'b0}};
                    end
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_BURST: begin
                if (armed_r && en && credit_s && !src_empty[grant_r] && (cnt_r < BURST_C)) begin
                    issue_s = 1'b1;
                    cnt_s   = cnt_r + CNT_W'(1);
                    if ((cnt_s == BURST_C) || src_one_left[grant_r]) begin
                        state_s  = ARB_IDLE;
                        cnt_s    = {CNT_W{1'b0}};
                        rr_ptr_s = SRC_W'(wrap_inc(int'(grant_r), NUM_SRC));
                    end else begin
                        state_s = ARB_BURST;
                    end
                end else if (src_empty[grant_r]) begin
                    state_s  = ARB_IDLE;
                    cnt_s    = {CNT_W{1'b0}};
                    rr_ptr_s = SRC_W'(wrap_inc(int'(grant_r), NUM_SRC));
                end else begin
                    state_s = ARB_BURST;
                end
            end
            default: begin
                state_s = ARB_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // One-hot read strobe toward the granted source.
    always_comb begin
        src_rd_en = {NUM_SRC{1'b0}};
        if (issue_s) begin
            src_rd_en[issue_idx_s] = 1'b1;
        end else begin
            src_rd_en = {NUM_SRC{1'b0}};
        end
    end

    // FSM state, arbitration pointer and in-flight tracking; armed_r masks reads right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ARB_IDLE;
            grant_r    <= {SRC_W{1'b0}};
            rr_ptr_r   <= {SRC_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            armed_r    <= 1'b0;
            inflight_r <= 1'b0;
            infl_src_r <= {SRC_W{1'b0}};
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            rr_ptr_r   <= rr_ptr_s;
            cnt_r      <= cnt_s;
            armed_r    <= 1'b1;
            inflight_r <= issue_s;
            if (issue_s) begin
                infl_src_r <= issue_idx_s;
            end
        end
    end

    // Output buffer: the in-flight word lands here unless the consumer takes it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARB_BUF_DEPTH; i++) begin
                buf_data_r[i] <= {WIDTH{1'b0}};
                buf_src_r[i]  <= {SRC_W{1'b0}};
            end
            buf_wp_r  <= 1'b0;
            buf_rp_r  <= 1'b0;
            buf_cnt_r <= 2'd0;
        end else begin
            if (push_s) begin
                buf_data_r[buf_wp_r] <= infl_data_s;
                buf_src_r[buf_wp_r]  <= infl_src_r;
                buf_wp_r             <= ~buf_wp_r;
            end
            if (bpop_s) begin
                buf_rp_r <= ~buf_rp_r;
            end
            buf_cnt_r <= buf_cnt_r + {1'b0, push_s} - {1'b0, bpop_s};
        end
    end

    // Head of stream: oldest buffered word, else the word arriving from the source this cycle.
    always_comb begin
        if (buf_cnt_r != 2'd0) begin
            out_valid = 1'b1;
            out_data  = buf_data_r[buf_rp_r];
            out_src   = buf_src_r[buf_rp_r];
        end else if (inflight_r) begin
            out_valid = 1'b1;
            out_data  = infl_data_s;
            out_src   = infl_src_r;
        end else begin
            out_valid = 1'b0;
            out_data  = {WIDTH{1'b0}};
            out_src   = {SRC_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Self-checking bench: behavioural source FIFOs plus a round-robin schedule model as scoreboard.
module tb_fifo_rr_drain;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int B  = 4;
    localparam int SW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               out_ready = 1'b0;
    logic [N-1:0]       src_empty;
    logic [N-1:0]       src_one_left;
    logic [N*W-1:0]     src_rd_data;
    logic [N-1:0]       src_rd_en;
    logic               out_valid;
    logic [W-1:0]       out_data;
    logic [SW-1:0]      out_src;
    logic               busy;

    fifo_rr_drain #(.WIDTH(W), .NUM_SRC(N), .BURST(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .src_empty    (src_empty),
        .src_one_left (src_one_left),
        .src_rd_data  (src_rd_data),
        .src_rd_en    (src_rd_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_src      (out_src),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [W-1:0]     mem [N][16];
    int               head [N];
    int               cnt [N];
    logic [SW+W-1:0]  exp_q [$];
    int               model_ptr = 0;
    int               cyc, n_rd, n_out, first_rd, last_rd, first_out, last_out;
    int               first_src;
    logic             prev_hold;
    logic [W-1:0]     prev_data;
    logic [SW-1:0]    prev_src;
    int               rdy_mode = 0;
    int               en_mode = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            src_empty[i]    = (cnt[i] == 0);
            src_one_left[i] = (cnt[i] == 1);
        end
    endtask

    task automatic load(input int s, input int n);
        head[s] = 0;
        cnt[s]  = n;
        for (int j = 0; j < n; j++) mem[s][j] = $urandom;
        refresh();
    endtask

    // Expected stream: from the pointer, first non-empty source gets min(BURST, remaining) words.
    task automatic build_exp();
        int rc [N];
        int hd [N];
        int p, g, take;
        for (int i = 0; i < N; i++) begin
            rc[i] = cnt[i];
            hd[i] = head[i];
        end
        p = model_ptr;
        for (int iter = 0; iter < 64; iter++) begin
            g = -1;
            for (int k = 0; k < N; k++) if (g < 0 && rc[(p + k) % N] > 0) g = (p + k) % N;
            if (g < 0) break;
            take = (rc[g] < B) ? rc[g] : B;
            for (int j = 0; j < take; j++) exp_q.push_back({SW'(g), mem[g][hd[g] + j]});
            hd[g] += take;
            rc[g] -= take;
            p = (g + 1) % N;
        end
        model_ptr = p;
    endtask

    task automatic start_scn();
        cyc = 0; n_rd = 0; n_out = 0; first_rd = 0; last_rd = 0;
        first_out = 0; last_out = 0; first_src = -1; prev_hold = 1'b0;
    endtask

    task automatic drive();
        en        = (en_mode == 2) ? (($urandom % 4) != 0) : (en_mode == 1);
        out_ready = (rdy_mode == 2) ? (($urandom % 3) != 0) : (rdy_mode == 1);
    endtask

    // One clock: sample at negedge, then advance the source models just after posedge.
    task automatic step();
        logic [N-1:0]    rd_snap;
        logic [SW+W-1:0] e;
        @(negedge clk);
        cyc++;
        chk("onehot0", $onehot0(src_rd_en), 1);
        chk("rd_of_empty", |(src_rd_en & src_empty), 0);
        if (prev_hold) chk("hold_stable", {out_valid, out_src, out_data}, {1'b1, prev_src, prev_data});
        if (|src_rd_en) begin
            n_rd++;
            if (first_rd == 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (first_out == 0) first_out = cyc;
            last_out = cyc;
            if (first_src < 0) first_src = int'(out_src);
            if (exp_q.size() == 0) begin
                chk("extra_word", {out_src, out_data}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_word", {out_src, out_data}, e);
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_src  = out_src;
        rd_snap   = src_rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd_snap[i] && cnt[i] > 0) begin
                src_rd_data[i*W +: W] = mem[i][head[i]];
                head[i]++;
                cnt[i]--;
            end
        end
        refresh();
        drive();
    endtask

    task automatic run(input string tag, input int budget);
        int k = 0;
        int tot = 0;
        while ((exp_q.size() != 0 || busy === 1'b1) && k < budget) begin
            step();
            k++;
        end
        for (int i = 0; i < N; i++) tot += cnt[i];
        chk({tag, "_timeout"}, (k < budget), 1);
        chk({tag, "_left_exp"}, exp_q.size(), 0);
        chk({tag, "_left_src"}, tot, 0);
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; out_ready = 1'b0;
        rdy_mode = 0; en_mode = 0; model_ptr = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("rst_state", {src_rd_en, out_valid, out_src, out_data, busy}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
        end
        src_rd_data = '0;
        refresh();
        do_reset();

        // 1: single source, three words, exact latency
        en_mode = 1; rdy_mode = 1; en = 1'b1; out_ready = 1'b1;
        load(0, 3);
        build_exp();
        start_scn();
        run("t1", 40);
        chk("t1_rd_cycles", {32'(first_rd), 32'(last_rd)}, {32'd1, 32'd3});
        chk("t1_n_rd", n_rd, 3);
        chk("t1_out_cycles", {32'(first_out), 32'(last_out)}, {32'd2, 32'd4});

        // 2: all sources loaded, continuous flow
        do_reset();
        en_mode = 1; rdy_mode = 1; en = 1'b1; out_ready = 1'b1;
        for (int s = 0; s < N; s++) load(s, 8);
        build_exp();
        start_scn();
        run("t2", 200);
        chk("t2_n_out", n_out, 32);
        chk("t2_no_bubble_out", last_out - first_out, 31);
        chk("t2_no_bubble_rd", last_rd - first_rd, 31);

        // 3: consumer stalled, credits limit reads to two
        rdy_mode = 0; out_ready = 1'b0;
        load(1, 4);
        build_exp();
        start_scn();
        for (int k = 0; k < 8; k++) step();
        chk("t3_n_rd_stall", n_rd, 2);
        chk("t3_head", {out_valid, out_src, out_data}, {1'b1, 2'd1, mem[1][0]});
        rdy_mode = 1; out_ready = 1'b1;
        run("t3", 60);

        // 4: pointer at 2, sources 0 and 3 -> wrap order 3 then 0
        rdy_mode = 2;
        load(0, 3);
        load(3, 3);
        build_exp();
        start_scn();
        run("t4", 100);
        chk("t4_first_src", first_src, 3);

        // 5: enable dropped after the second read of a burst
        rdy_mode = 1; en_mode = 1; en = 1'b1; out_ready = 1'b1;
        load(1, 8);
        load(2, 4);
        build_exp();
        start_scn();
        for (int k = 0; k < 10 && n_rd < 2; k++) step();
        chk("t5_two_reads", n_rd, 2);
        en_mode = 0; en = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("t5_no_rd_en_off", n_rd, 2);
        chk("t5_inflight_out", n_out, 2);
        en_mode = 1; en = 1'b1;
        run("t5", 100);

        // 6: asynchronous reset with a full buffer mid-burst
        rdy_mode = 0; out_ready = 1'b0; en_mode = 1; en = 1'b1;
        load(0, 6);
        for (int s = 1; s < N; s++) load(s, 4);
        start_scn();
        for (int k = 0; k < 4; k++) step();
        chk("t6_pre_full", {out_valid, busy}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {src_rd_en, out_valid, busy}, 0);
        @(posedge clk);
        #1;
        chk("t6_rd_in_reset", src_rd_en, 0);
        rst_n = 1'b1;
        exp_q.delete();
        model_ptr = 0;
        rdy_mode = 1; out_ready = 1'b1;
        build_exp();
        start_scn();
        step();
        chk("t6_no_rd_after_rst", n_rd, 0);
        run("t6", 200);
        chk("t6_first_src", first_src, 0);

        // 7: random loads, random stalls on both sides
        for (int it = 0; it < 4; it++) begin
            rdy_mode = 2; en_mode = 2;
            for (int s = 0; s < N; s++) load(s, $urandom_range(0, 8));
            build_exp();
            start_scn();
            run("t7", 600);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
